pt_write_port: RTL and testbench

Write-side responder for the projective-transform pixel stream. Accepts `pt_pixel_write`/`pt_x`/`pt_y`/`pt_wr` writes, raises `ptflag` when it can take more, buffers requests in a small FIFO and issues packed ZBT SRAM word writes through a request/grant port. Double-buffers frames: writes go to one SRAM bank while the display reader scans the other, and banks swap on `frame_flag`.

---
 rtl/pt_write_port.sv | 161 ++++++++++++++++
 tb/tb_pt_write_port.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pt_write_port.sv
`default_nettype none
// ============================================================================
// Module   : pt_write_port
// Purpose  : Write-side responder for the projective-transform pixel stream.
//            Buffers pixel writes in a small FIFO and issues packed ZBT SRAM
//            word writes through a request/grant port. Frames are double
//            buffered: writes target one bank while the display reader scans
//            the other; banks swap after a frame_flag once the FIFO drains.
// Ports    : clk, reset (async, active high)
//            frame_flag              - new-frame pulse, requests bank swap
//            pt_pixel_write/pt_x/pt_y/pt_wr - pixel write from producer
//            ptflag                  - producer may issue writes
//            mem_req/mem_grant       - SRAM arbiter handshake
//            mem_addr/mem_data/mem_bwe - head-of-FIFO SRAM write word
//            display_bank            - bank scanned by the display reader
//            drop_count              - clipped-pixel counter
// Options  : PT_CLIP_EN - drop pixels outside 640x480 and count them
// Revision : 1.0 - initial release
// ============================================================================
module pt_write_port #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_flag,
    input  logic [17:0] pt_pixel_write,
    input  logic [9:0]  pt_x,
    input  logic [8:0]  pt_y,
    input  logic        pt_wr,
    output logic        ptflag,
    output logic        mem_req,
    input  logic        mem_grant,
    output logic [18:0] mem_addr,
    output logic [35:0] mem_data,
    output logic [3:0]  mem_bwe,
    output logic        display_bank,
    output logic [15:0] drop_count
);

    localparam int             c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_FULL    = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]  c_HIGH_WM = (c_AW+1)'(DEPTH - 2);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_AW:0]     r_count;
    logic [c_AW:0]     w_count_nxt;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic              r_bank;
    logic              r_ptflag;
    logic [40:0]       r_fifo [DEPTH];

    logic              w_in_range;
    logic              w_accept_state;
    logic              w_push_req;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [18:0]       w_addr;
    logic [3:0]        w_bwe;
    logic [40:0]       w_head;

`ifdef PT_CLIP_EN
    assign w_in_range = (pt_x < 10'd640) && (pt_y < 9'd480);
`else
    assign w_in_range = 1'b1;
`endif

    assign w_accept_state = (r_state != ST_SWAP);
    assign w_push_req     = pt_wr && w_accept_state && w_in_range;
    assign w_empty        = (r_count == '0);
    assign w_full         = (r_count == c_FULL);
    assign w_pop          = !w_empty && mem_grant;
    // A full FIFO can still take a write if the head leaves this cycle.
    assign w_push         = w_push_req && (!w_full || w_pop);

    // Address is bound to the write bank at push time so entries queued
    // before a swap still land in the old bank.
    assign w_addr = {r_bank, pt_y, pt_x[9:1]};
    assign w_bwe  = pt_x[0] ? 4'b1100 : 4'b0011;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (frame_flag) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_empty && !w_push) w_state_nxt = ST_SWAP;
            ST_SWAP:  w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_bank   <= 1'b0;
            r_ptflag <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_state == ST_SWAP) r_bank <= ~r_bank;
            // Headroom of two entries covers the producer's one-cycle
            // reaction to ptflag falling.
            r_ptflag <= (w_count_nxt <= c_HIGH_WM) && (w_state_nxt == ST_RUN);
        end
    end

    // Storage needs no reset: outputs are gated by the empty flag.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {w_addr, w_bwe, pt_pixel_write};
    end

    assign w_head       = r_fifo[r_rd_ptr];
    assign mem_req      = !w_empty;
    assign mem_addr     = w_empty ? 19'd0 : w_head[40:22];
    assign mem_bwe      = w_empty ? 4'd0  : w_head[21:18];
    assign mem_data     = w_empty ? 36'd0 : {w_head[17:0], w_head[17:0]};
    assign ptflag       = r_ptflag;
    assign display_bank = ~r_bank;

`ifdef PT_CLIP_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_count <= 16'd0;
        end else if (r_state == ST_SWAP) begin
            r_drop_count <= 16'd0;
        end else if (pt_wr && !w_in_range && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pt_write_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_pt_write_port
// Purpose  : Self-checking bench for pt_write_port: table of single-write
//            vectors plus directed sequences for fill/drain, simultaneous
//            push/pop, bank swap, clipping (PT_CLIP_EN) and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pt_write_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_flag;
    logic [17:0] pt_pixel_write;
    logic [9:0]  pt_x;
    logic [8:0]  pt_y;
    logic        pt_wr;
    logic        ptflag;
    logic        mem_req;
    logic        mem_grant;
    logic [18:0] mem_addr;
    logic [35:0] mem_data;
    logic [3:0]  mem_bwe;
    logic        display_bank;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    pt_write_port #(.DEPTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_flag     (frame_flag),
        .pt_pixel_write (pt_pixel_write),
        .pt_x           (pt_x),
        .pt_y           (pt_y),
        .pt_wr          (pt_wr),
        .ptflag         (ptflag),
        .mem_req        (mem_req),
        .mem_grant      (mem_grant),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_bwe        (mem_bwe),
        .display_bank   (display_bank),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [17:0] pix;
        logic [18:0] addr;
        logic [3:0]  bwe;
        logic [35:0] data;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write1(input logic [9:0] x, input logic [8:0] y, input logic [17:0] p);
        pt_wr = 1'b1; pt_x = x; pt_y = y; pt_pixel_write = p;
        step();
        pt_wr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bit seen;
        logic [17:0] p;

        vecs[0] = '{10'd5,    9'd2,   18'h2ABCD, 19'h00402, 4'b1100, {18'h2ABCD, 18'h2ABCD}};
        vecs[1] = '{10'd0,    9'd0,   18'h3FFFF, 19'h00000, 4'b0011, 36'hF_FFFF_FFFF};
        vecs[2] = '{10'd639,  9'd479, 18'h12345, 19'h3BF3F, 4'b1100, {18'h12345, 18'h12345}};
        vecs[3] = '{10'd2,    9'd1,   18'h00001, 19'h00201, 4'b0011, 36'h0_0004_0001};
        vecs[4] = '{10'd300,  9'd100, 18'h20000, 19'h0C896, 4'b0011, 36'h8_0002_0000};

        reset = 1'b1; frame_flag = 1'b0; pt_wr = 1'b0; pt_x = '0; pt_y = '0;
        pt_pixel_write = '0; mem_grant = 1'b0;

        // ---- reset values ----
        step(); step();
        chk("rst_ptflag", ptflag, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_mem_bwe", mem_bwe, 0);
        chk("rst_display_bank", display_bank, 1);
        chk("rst_drop_count", drop_count, 0);
        reset = 1'b0;
        chk("rel_ptflag_before_edge", ptflag, 0);
        step();
        chk("rel_ptflag_first_cycle", ptflag, 1);

        // ---- table of single writes, grant held high ----
        mem_grant = 1'b1;
        for (int i = 0; i < 5; i++) begin
            write1(vecs[i].x, vecs[i].y, vecs[i].pix);
            chk($sformatf("vec%0d_req", i), mem_req, 1);
            chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
            chk($sformatf("vec%0d_bwe", i), mem_bwe, vecs[i].bwe);
            chk($sformatf("vec%0d_data", i), mem_data, vecs[i].data);
            step();
            chk($sformatf("vec%0d_req_done", i), mem_req, 0);
        end

        // ---- fill with grant low: ptflag falls at count 7, 8 stored ----
        mem_grant = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill%0d_ptflag", i), ptflag, (i <= 6) ? 1 : 0);
            pt_wr = 1'b1; pt_x = 10'(2 * i); pt_y = 9'd3;
            pt_pixel_write = 18'(i + 'h100);
            step();
        end
        pt_wr = 1'b0;
        chk("full_ptflag", ptflag, 0);
        chk("full_req", mem_req, 1);
        // Protocol error: write into a full FIFO must be discarded.
        write1(10'd0, 9'd0, 18'h3FFFF);
        mem_grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            p = 18'(i + 'h100);
            chk($sformatf("drain%0d_req", i), mem_req, 1);
            chk($sformatf("drain%0d_data", i), mem_data, {p, p});
            chk($sformatf("drain%0d_addr", i), mem_addr, {1'b0, 9'd3, 9'(i)});
            step();
        end
        chk("drain_empty", mem_req, 0);

        // ---- simultaneous push and pop at count 6 ----
        mem_grant = 1'b0;
        for (int i = 0; i < 6; i++) write1(10'(i), 9'd7, 18'(i));
        chk("cnt6_ptflag", ptflag, 1);
        mem_grant = 1'b1;
        write1(10'd20, 9'd7, 18'h00020);
        chk("pushpop_ptflag", ptflag, 1);
        mem_grant = 1'b0;
        write1(10'd21, 9'd7, 18'h00021);
        chk("cnt7_ptflag", ptflag, 0);
        mem_grant = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!mem_req) break;
            n++;
            step();
        end
        chk("pushpop_word_count", n, 7);

        // ---- bank swap with 3 queued, grant every other cycle ----
        mem_grant = 1'b0;
        for (int i = 0; i < 3; i++) write1(10'(i), 9'd9, 18'(i + 'h50));
        frame_flag = 1'b1;
        step();
        frame_flag = 1'b0;
        chk("drain_ptflag_low", ptflag, 0);
        chk("drain_bank_old", display_bank, 1);
        seen = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            mem_grant  = cyc[0];
            frame_flag = (cyc == 2);
            step();
            frame_flag = 1'b0;
            if (!mem_req) begin
                seen = 1'b1;
                break;
            end
            chk($sformatf("drain_cyc%0d_ptflag", cyc), ptflag, 0);
        end
        mem_grant = 1'b0;
        chk("drain_completed", seen, 1);
        chk("empty_ptflag", ptflag, 0);
        chk("empty_bank", display_bank, 1);
        step();
        chk("swap_ptflag", ptflag, 0);
        chk("swap_bank", display_bank, 1);
        step();
        chk("after_swap_bank", display_bank, 0);
        chk("after_swap_ptflag", ptflag, 1);
        step(); step(); step();
        chk("single_swap_bank", display_bank, 0);
        mem_grant = 1'b1;
        write1(10'd5, 9'd2, 18'h2ABCD);
        chk("bank1_req", mem_req, 1);
        chk("bank1_addr", mem_addr, 19'h40402);
        step();

`ifdef PT_CLIP_EN
        // ---- clipping ----
        write1(10'd640, 9'd0, 18'h00111);
        chk("clip_x_req", mem_req, 0);
        write1(10'd0, 9'd480, 18'h00222);
        chk("clip_y_req", mem_req, 0);
        chk("clip_drop2", drop_count, 2);
        write1(10'd639, 9'd479, 18'h00155);
        chk("clip_in_req", mem_req, 1);
        chk("clip_in_addr", mem_addr, 19'h7BF3F);
        chk("clip_in_drop", drop_count, 2);
        step();
        chk("clip_in_done", mem_req, 0);
        frame_flag = 1'b1;
        step();
        frame_flag = 1'b0;
        chk("clip_swap_drain_ptflag", ptflag, 0);
        step();
        chk("clip_swap_state_ptflag", ptflag, 0);
        step();
        chk("clip_swap_ptflag", ptflag, 1);
        chk("clip_swap_bank", display_bank, 1);
        chk("clip_drop_cleared", drop_count, 0);
`else
        // ---- out-of-range coordinates pass through unmodified ----
        write1(10'd1023, 9'd511, 18'h2AAAA);
        chk("oor_req", mem_req, 1);
        chk("oor_addr", mem_addr, 19'h7FFFF);
        chk("oor_bwe", mem_bwe, 4'b1100);
        step();
        chk("oor_done", mem_req, 0);
        chk("oor_drop", drop_count, 0);
`endif

        // ---- asynchronous reset mid-grant ----
        mem_grant = 1'b0;
        for (int i = 0; i < 5; i++) write1(10'(i), 9'd4, 18'(i + 'h70));
        mem_grant = 1'b1;
        step();
        chk("pre_rst_req", mem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_req", mem_req, 0);
        chk("async_rst_ptflag", ptflag, 0);
        chk("async_rst_bank", display_bank, 1);
        chk("async_rst_addr", mem_addr, 0);
        chk("async_rst_data", mem_data, 0);
        mem_grant = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post_rst_req", mem_req, 0);
        step();
        chk("post_rst_ptflag", ptflag, 1);
        chk("post_rst_empty", mem_req, 0);
        chk("post_rst_bank", display_bank, 1);
        mem_grant = 1'b1;
        write1(10'd5, 9'd2, 18'h2ABCD);
        chk("post_rst_addr", mem_addr, 19'h00402);
        step();
        chk("post_rst_done", mem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
